// File: rtl/ddr3_rpt_pkg.sv
// Shared definitions for the DDR3 result reporter: FSM encoding, message lengths,
// ASCII constants and the nibble-to-hex helper.
package ddr3_rpt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_WAIT = 2'd3
   } rpt_state_t;

   localparam int MSG_LEN_BASE  = 27;
   localparam int MSG_LEN_STATE = 31;
   localparam int MSG_IDX_W     = 5;

   localparam logic [7:0] ASCII_P  = 8'h50;
   localparam logic [7:0] ASCII_O  = 8'h4F;
   localparam logic [7:0] ASCII_K  = 8'h4B;
   localparam logic [7:0] ASCII_N  = 8'h4E;
   localparam logic [7:0] ASCII_G  = 8'h47;
   localparam logic [7:0] ASCII_S  = 8'h53;
   localparam logic [7:0] ASCII_EQ = 8'h3D;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Uppercase hex digit for one nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/ddr3_uart_tx.sv
// 8N1 UART serializer. done pulses three clocks before the stop bit ends so the
// caller can select and issue the next byte for a gap-free stream (CLKS_PER_BIT >= 3).
module ddr3_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       start,
   output logic       txd,
   output logic       done
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic          active_reg;
   logic [3:0]    bit_idx_reg;
   logic [CW-1:0] cnt_reg;
   logic [7:0]    shift_reg;
   logic          txd_reg;
   logic          bit_end;
   logic          in_stop;
   logic          load;

   assign bit_end = (cnt_reg == CW'(CLKS_PER_BIT - 1));
   assign in_stop = (bit_idx_reg == 4'd9);
   // A new byte is taken when idle or exactly as the current stop bit ends.
   assign load    = start && (!active_reg || (in_stop && bit_end));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_reg  <= 1'b0;
         bit_idx_reg <= 4'd0;
         cnt_reg     <= '0;
         shift_reg   <= 8'h00;
         txd_reg     <= 1'b1;
      end else if (load) begin
         active_reg  <= 1'b1;
         bit_idx_reg <= 4'd0;
         cnt_reg     <= '0;
         shift_reg   <= data;
         txd_reg     <= 1'b0;
      end else if (active_reg) begin
         if (bit_end) begin
            cnt_reg <= '0;
            if (in_stop) begin
               active_reg <= 1'b0;
            end else begin
               // Ones shifted in from the top become the stop bit after eight shifts.
               bit_idx_reg <= bit_idx_reg + 4'd1;
               txd_reg     <= shift_reg[0];
               shift_reg   <= {1'b1, shift_reg[7:1]};
            end
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign txd  = txd_reg;
   assign done = active_reg && in_stop && (cnt_reg == CW'(CLKS_PER_BIT - 3));

endmodule

// File: rtl/ddr3_result_reporter.sv
// Reports each DDR3 test pass as an ASCII line over UART and drives status LEDs.
// Define DDR3_RPT_STATE_EN to append " S=<state>" to every report.
module ddr3_result_reporter
   import ddr3_rpt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdone,
   input  logic [23:0] num_ok,
   input  logic [23:0] num_ng,
   input  logic [2:0]  test_state,
   output logic        uart_txd,
   output logic        busy,
   output logic [15:0] pass_cnt,
   output logic        led_ok,
   output logic        led_ng,
   output logic        overrun
);

`ifdef DDR3_RPT_STATE_EN
   localparam int MSG_LEN = MSG_LEN_STATE;
`else
   localparam int MSG_LEN = MSG_LEN_BASE;
`endif

   rpt_state_t           state_reg;
   rpt_state_t           state_next;
   logic                 rdone_reg;
   logic                 pass_event;
   logic                 accept;
   logic [15:0]          pass_cnt_reg;
   logic [15:0]          snap_cnt;
   logic [23:0]          snap_ok;
   logic [23:0]          snap_ng;
   logic [MSG_IDX_W-1:0] char_idx;
   logic [7:0]           char_reg;
   logic [1:0]           tail_reg;
   logic                 last_char;
   logic                 tx_start;
   logic                 tx_done;
   logic [7:0]           msg [MSG_LEN];
   logic [7:0]           msg_char;

   assign pass_event = rdone && !rdone_reg;
   assign accept     = pass_event && (state_reg == ST_IDLE);
   assign last_char  = (char_idx == MSG_IDX_W'(MSG_LEN - 1));

   assign msg[0] = ASCII_P;
   for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      assign msg[1+gi] = hex_ascii(snap_cnt[15-4*gi -: 4]);
   end
   assign msg[5] = ASCII_SP;
   assign msg[6] = ASCII_O;
   assign msg[7] = ASCII_K;
   assign msg[8] = ASCII_EQ;
   for (genvar gi = 0; gi < 6; gi++) begin : g_ok
      assign msg[9+gi] = hex_ascii(snap_ok[23-4*gi -: 4]);
   end
   assign msg[15] = ASCII_SP;
   assign msg[16] = ASCII_N;
   assign msg[17] = ASCII_G;
   assign msg[18] = ASCII_EQ;
   for (genvar gi = 0; gi < 6; gi++) begin : g_ng
      assign msg[19+gi] = hex_ascii(snap_ng[23-4*gi -: 4]);
   end

`ifdef DDR3_RPT_STATE_EN
   logic [2:0] snap_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         snap_state <= 3'd0;
      else if (accept)
         snap_state <= test_state;
   end

   assign msg[25] = ASCII_SP;
   assign msg[26] = ASCII_S;
   assign msg[27] = ASCII_EQ;
   assign msg[28] = hex_ascii({1'b0, snap_state});
`else
   logic unused_state;
   assign unused_state = ^test_state;
`endif

   assign msg[MSG_LEN-2] = ASCII_CR;
   assign msg[MSG_LEN-1] = ASCII_LF;
   assign msg_char       = msg[char_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = ST_LOAD;
         ST_LOAD: state_next = ST_SEND;
         ST_SEND: state_next = ST_WAIT;
         ST_WAIT: begin
            if (tail_reg == 2'd1)
               state_next = ST_IDLE;
            else if (tx_done && !last_char)
               state_next = ST_LOAD;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_reg != ST_IDLE);
      tx_start = (state_reg == ST_SEND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdone_reg    <= 1'b0;
         pass_cnt_reg <= 16'h0000;
         snap_cnt     <= 16'h0000;
         snap_ok      <= 24'h000000;
         snap_ng      <= 24'h000000;
         led_ok       <= 1'b0;
         led_ng       <= 1'b0;
         overrun      <= 1'b0;
         char_idx     <= '0;
         char_reg     <= 8'h00;
         tail_reg     <= 2'd0;
      end else begin
         rdone_reg <= rdone;
         if (pass_event)
            pass_cnt_reg <= pass_cnt_reg + 16'd1;
         if (pass_event && !accept)
            overrun <= 1'b1;
         if (accept) begin
            snap_cnt <= pass_cnt_reg + 16'd1;
            snap_ok  <= num_ok;
            snap_ng  <= num_ng;
            led_ok   <= (num_ng == 24'd0);
            if (num_ng != 24'd0)
               led_ng <= 1'b1;
            char_idx <= '0;
         end
         if (state_reg == ST_LOAD)
            char_reg <= msg_char;
         // After the last early done, hold busy through the final two stop-bit clocks.
         if ((state_reg == ST_WAIT) && tx_done) begin
            if (last_char)
               tail_reg <= 2'd2;
            else
               char_idx <= char_idx + MSG_IDX_W'(1);
         end else if (tail_reg != 2'd0) begin
            tail_reg <= tail_reg - 2'd1;
         end
      end
   end

   assign pass_cnt = pass_cnt_reg;

   ddr3_uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .data (char_reg),
      .start(tx_start),
      .txd  (uart_txd),
      .done (tx_done)
   );

endmodule

// File: tb/tb_ddr3_result_reporter.sv
// Directed bench for ddr3_result_reporter: decodes the UART line and compares each
// report against hand-written strings, plus LED, counter, overrun, wrap and reset cases.
module tb_ddr3_result_reporter;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
`ifdef DDR3_RPT_STATE_EN
   localparam int MLEN = 31;
`else
   localparam int MLEN = 27;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rdone;
   logic [23:0] num_ok;
   logic [23:0] num_ng;
   logic [2:0]  test_state;
   logic        uart_txd;
   logic        busy;
   logic [15:0] pass_cnt;
   logic        led_ok;
   logic        led_ng;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] rxq[$];
   bit         rx_active = 1'b0;
   int         rx_cnt    = 0;
   logic [7:0] rx_byte   = 8'h00;
   int         first_start = -1;
   int         frame_err   = 0;

   ddr3_result_reporter #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rdone     (rdone),
      .num_ok    (num_ok),
      .num_ng    (num_ng),
      .test_state(test_state),
      .uart_txd  (uart_txd),
      .busy      (busy),
      .pass_cnt  (pass_cnt),
      .led_ok    (led_ok),
      .led_ng    (led_ng),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART receiver sampling mid-bit on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (uart_txd === 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            if (first_start < 0) first_start = cyc;
         end
      end else begin
         rx_cnt++;
         if ((rx_cnt % CPB == 2) && (rx_cnt >= CPB + 2) && (rx_cnt <= 8 * CPB + 2))
            rx_byte = {uart_txd, rx_byte[7:1]};
         if (rx_cnt == 9 * CPB + 2) begin
            if (uart_txd !== 1'b1) frame_err++;
            rxq.push_back(rx_byte);
         end
         if (rx_cnt == FRAME - 1) rx_active = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [23:0] ok, input logic [23:0] ng, input logic [2:0] st,
                        output int ev);
      @(negedge clk);
      num_ok     = ok;
      num_ng     = ng;
      test_state = st;
      rdone      = 1'b1;
      ev         = cyc + 1;
      @(negedge clk);
      rdone  = 1'b0;
      num_ok = 24'h5A5A5A;
      num_ng = 24'hA5A5A5;
   endtask

   task automatic expect_report(input string tag, input string body, input int ev,
                                input logic [2:0] st);
      string exp_s;
      string got;
      int    n;
      logic [7:0] c;
`ifdef DDR3_RPT_STATE_EN
      exp_s = {body, $sformatf(" S=%0d", st), "\r\n"};
`else
      exp_s = {body, "\r\n"};
      if (st == 3'd7) exp_s = {body, "\r\n"};
`endif
      check({tag, "_busy_rise"}, 32'(busy), 1);
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_timeout"}, 32'(n < 3000), 1);
      check({tag, "_start_latency"}, 32'(first_start >= 0 && first_start - ev <= 3), 1);
      check({tag, "_busy_fall"}, 32'(cyc - first_start), 32'(FRAME * MLEN));
      check({tag, "_len"}, 32'(rxq.size()), 32'(MLEN));
      got = "";
      for (int i = 0; i < MLEN; i++) begin
         c = (i < rxq.size()) ? rxq[i] : 8'h00;
         check($sformatf("%s_char%0d", tag, i), 32'(c), 32'(exp_s[i]));
         if (c >= 8'h20) got = $sformatf("%s%c", got, c);
      end
      check({tag, "_framing"}, 32'(frame_err), 0);
      $display("report %s: \"%s\" pass_cnt=%04h led_ok=%0b led_ng=%0b overrun=%0b",
               tag, got, pass_cnt, led_ok, led_ng, overrun);
   endtask

   task automatic clear_rx();
      rxq.delete();
      first_start = -1;
   endtask

   initial begin
      int ev;
      int ev2;
      int n;
      int saved;
      rst        = 1'b1;
      rdone      = 1'b0;
      num_ok     = 24'h0;
      num_ng     = 24'h0;
      test_state = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(uart_txd), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_pass_cnt", 32'(pass_cnt), 0);
      check("rst_led_ok", 32'(led_ok), 0);
      check("rst_led_ng", 32'(led_ng), 0);
      check("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean single pass
      clear_rx();
      pulse(24'h001000, 24'h000000, 3'd5, ev);
      expect_report("single", "P0001 OK=001000 NG=000000", ev, 3'd5);
      check("single_led_ok", 32'(led_ok), 1);
      check("single_led_ng", 32'(led_ng), 0);
      check("single_pass_cnt", 32'(pass_cnt), 1);
      check("single_overrun", 32'(overrun), 0);

      // Error pass then clean pass: led_ng must stick
      clear_rx();
      pulse(24'h000FFE, 24'h000002, 3'd2, ev);
      expect_report("error", "P0002 OK=000FFE NG=000002", ev, 3'd2);
      check("error_led_ok", 32'(led_ok), 0);
      check("error_led_ng", 32'(led_ng), 1);
      clear_rx();
      pulse(24'h000123, 24'h000000, 3'd3, ev);
      expect_report("clean", "P0003 OK=000123 NG=000000", ev, 3'd3);
      check("clean_led_ok", 32'(led_ok), 1);
      check("clean_led_ng", 32'(led_ng), 1);

      // Second pass 100 cycles into a report is dropped but counted
      clear_rx();
      pulse(24'h00ABCD, 24'h00000F, 3'd4, ev);
      repeat (98) @(negedge clk);
      pulse(24'h111111, 24'h000000, 3'd6, ev2);
      check("ovr_flag_early", 32'(overrun), 1);
      expect_report("overrun", "P0004 OK=00ABCD NG=00000F", ev, 3'd4);
      check("ovr_pass_cnt", 32'(pass_cnt), 5);
      check("ovr_led_ok", 32'(led_ok), 0);
      repeat (200) @(negedge clk);
      check("ovr_single_report", 32'(rxq.size()), 32'(MLEN));
      check("ovr_busy_idle", 32'(busy), 0);
      clear_rx();
      pulse(24'hFFFFFF, 24'h100000, 3'd7, ev);
      expect_report("after_ovr", "P0006 OK=FFFFFF NG=100000", ev, 3'd7);

      // Counter wrap from 0xFFFF
      @(negedge clk);
      force dut.pass_cnt_reg = 16'hFFFF;
      #1 release dut.pass_cnt_reg;
      @(negedge clk);
      check("wrap_preload", 32'(pass_cnt), 32'h0000FFFF);
      clear_rx();
      pulse(24'h000001, 24'h000000, 3'd0, ev);
      expect_report("wrap", "P0000 OK=000001 NG=000000", ev, 3'd0);
      check("wrap_pass_cnt", 32'(pass_cnt), 0);

      // Reset asserted while the fifth character is on the line
      clear_rx();
      pulse(24'h000042, 24'h000000, 3'd1, ev);
      n = 0;
      while (!(rxq.size() == 4 && rx_active && uart_txd === 1'b0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("midrst_reach_char5", 32'(n < 2000), 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_txd", 32'(uart_txd), 1);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_pass_cnt", 32'(pass_cnt), 0);
      check("midrst_led_ok", 32'(led_ok), 0);
      check("midrst_led_ng", 32'(led_ng), 0);
      check("midrst_overrun", 32'(overrun), 0);
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      saved = rxq.size();
      repeat (1200) @(negedge clk);
      check("midrst_no_more_chars", 32'(rxq.size()), 32'(saved));
      check("midrst_chars_before", 32'(saved), 4);
      check("midrst_line_idle", 32'(uart_txd), 1);
      check("midrst_busy_idle", 32'(busy), 0);
      $display("reset mid-report: %0d characters received before reset", saved);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
